// File: rtl/otp_disp_pkg.sv
// Shared constants for the OTP display decoder: active-low 7-segment glyphs
// (bit6..0 = g..a), anode select codes and the publish FSM state type.
package otp_disp_pkg;

    localparam logic [6:0] GLYPH_0     = 7'h40;
    localparam logic [6:0] GLYPH_1     = 7'h79;
    localparam logic [6:0] GLYPH_2     = 7'h24;
    localparam logic [6:0] GLYPH_3     = 7'h30;
    localparam logic [6:0] GLYPH_4     = 7'h19;
    localparam logic [6:0] GLYPH_5     = 7'h12;
    localparam logic [6:0] GLYPH_6     = 7'h02;
    localparam logic [6:0] GLYPH_7     = 7'h78;
    localparam logic [6:0] GLYPH_8     = 7'h00;
    localparam logic [6:0] GLYPH_9     = 7'h10;
    localparam logic [6:0] GLYPH_A     = 7'h08;
    localparam logic [6:0] GLYPH_B     = 7'h03;
    localparam logic [6:0] GLYPH_C     = 7'h46;
    localparam logic [6:0] GLYPH_D     = 7'h21;
    localparam logic [6:0] GLYPH_E     = 7'h06;
    localparam logic [6:0] GLYPH_F     = 7'h0E;
    localparam logic [6:0] GLYPH_BLANK = 7'h7F;

    localparam logic [1:0] AN_DIGIT0  = 2'b10;
    localparam logic [1:0] AN_DIGIT1  = 2'b01;
    localparam logic [1:0] AN_BLANK   = 2'b11;
    localparam logic [1:0] AN_ILLEGAL = 2'b00;

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_PRESENT = 1'b1
    } disp_state_e;

endpackage

// File: rtl/otp_disp_decoder_seg7.sv
// Combinational 7-segment pattern to {legal, value} decoder; anything that
// is not one of the 16 hex glyphs reports legal = 0.
module otp_seg7_decode
    import otp_disp_pkg::*;
(
    input  logic [6:0] seg,
    output logic       legal,
    output logic [3:0] value
);

    always_comb begin
        legal = 1'b1;
        value = 4'h0;
        case (seg)
            GLYPH_0: value = 4'h0;
            GLYPH_1: value = 4'h1;
            GLYPH_2: value = 4'h2;
            GLYPH_3: value = 4'h3;
            GLYPH_4: value = 4'h4;
            GLYPH_5: value = 4'h5;
            GLYPH_6: value = 4'h6;
            GLYPH_7: value = 4'h7;
            GLYPH_8: value = 4'h8;
            GLYPH_9: value = 4'h9;
            GLYPH_A: value = 4'hA;
            GLYPH_B: value = 4'hB;
            GLYPH_C: value = 4'hC;
            GLYPH_D: value = 4'hD;
            GLYPH_E: value = 4'hE;
            GLYPH_F: value = 4'hF;
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/otp_disp_decoder.sv
// Recovers the OTP and user-entry digits from multiplexed 7-segment drive and
// publishes them with a valid/ready handshake. OTP_DISP_CHANGE_DET_EN adds code_changed.
//   state      | meaning
//   ST_COLLECT | waiting for all four digits (2 streams x 2 digits) to be captured
//   ST_PRESENT | codes published, code_valid high until code_ready
module otp_disp_decoder
    import otp_disp_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] lfsr_out,
    input  logic [6:0] user_out,
    input  logic [1:0] an,
    input  logic       code_ready,
    input  logic       err_clr,
    output logic       code_valid,
    output logic [7:0] otp_code,
    output logic [7:0] user_code,
    output logic       match,
    output logic       seg_err
`ifdef OTP_DISP_CHANGE_DET_EN
    ,
    output logic       code_changed
`endif
);

    localparam logic [3:0] CNT_MAX = 4'(STABLE_CYCLES);
    localparam logic [3:0] CNT_CAP = 4'(STABLE_CYCLES - 1);

    // Stream index 0 = lfsr_out, 1 = user_out; digit index from the anode.
    logic [1:0][6:0] pat;
    logic [1:0][3:0] dec;
    logic [1:0]      legal;
    logic            sel;
    logic            sel_valid;
    logic            err_now;
    logic            handshake;

    logic [1:0]           prev_an;
    logic [1:0][1:0][6:0] last_q;
    logic [1:0][1:0][3:0] cnt_q;
    logic [1:0][1:0][3:0] cap_q;
    logic [1:0][1:0]      flag_q;
    logic [7:0]           otp_next;
    logic [7:0]           user_next;
    disp_state_e          state;

    assign pat = {user_out, lfsr_out};

    otp_seg7_decode u_dec_otp (.seg(lfsr_out), .legal(legal[0]), .value(dec[0]));
    otp_seg7_decode u_dec_usr (.seg(user_out), .legal(legal[1]), .value(dec[1]));

    assign sel       = (an == AN_DIGIT1);
    assign sel_valid = (an == AN_DIGIT0) || (an == AN_DIGIT1);
    assign err_now   = (an == AN_ILLEGAL) || (sel_valid && !(&legal));
    assign handshake = code_valid && code_ready;
    assign otp_next  = {cap_q[0][1], cap_q[0][0]};
    assign user_next = {cap_q[1][1], cap_q[1][0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_an <= AN_BLANK;
            last_q  <= '0;
            cnt_q   <= '0;
            cap_q   <= '0;
            flag_q  <= '0;
            seg_err <= 1'b0;
        end else begin
            prev_an <= an;
            if (err_now)
                seg_err <= 1'b1;
            else if (err_clr)
                seg_err <= 1'b0;

            if (err_now || !sel_valid) begin
                cnt_q <= '0;
            end else begin
                for (int s = 0; s < 2; s++) begin
                    last_q[s][sel] <= pat[s];
                    if (an == prev_an && pat[s] == last_q[s][sel]) begin
                        if (cnt_q[s][sel] != CNT_MAX)
                            cnt_q[s][sel] <= cnt_q[s][sel] + 4'd1;
                        if (cnt_q[s][sel] == CNT_CAP) begin
                            cap_q[s][sel]  <= dec[s];
                            flag_q[s][sel] <= 1'b1;
                        end
                    end else begin
                        cnt_q[s][sel] <= 4'd1;
                    end
                end
            end

            // Accepting the published codes restarts collection from scratch.
            if (handshake)
                flag_q <= '0;
        end
    end

`ifdef OTP_DISP_CHANGE_DET_EN
    logic [7:0] prev_code;
    logic       prev_seen;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_COLLECT;
            code_valid <= 1'b0;
            otp_code   <= '0;
            user_code  <= '0;
            match      <= 1'b0;
`ifdef OTP_DISP_CHANGE_DET_EN
            code_changed <= 1'b0;
            prev_code    <= '0;
            prev_seen    <= 1'b0;
`endif
        end else begin
`ifdef OTP_DISP_CHANGE_DET_EN
            code_changed <= 1'b0;
`endif
            case (state)
                ST_COLLECT: begin
                    if (&flag_q) begin
                        state      <= ST_PRESENT;
                        code_valid <= 1'b1;
                        otp_code   <= otp_next;
                        user_code  <= user_next;
                        match      <= (otp_next == user_next);
`ifdef OTP_DISP_CHANGE_DET_EN
                        code_changed <= !prev_seen || (otp_next != prev_code);
                        prev_code    <= otp_next;
                        prev_seen    <= 1'b1;
`endif
                    end
                end
                ST_PRESENT: begin
                    if (code_ready) begin
                        state      <= ST_COLLECT;
                        code_valid <= 1'b0;
                        match      <= 1'b0;
                    end
                end
                default: begin
                    state      <= ST_COLLECT;
                    code_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_otp_disp_decoder.sv
// Self-checking bench for otp_disp_decoder: directed vector table, hand-written
// handshake/reset/change-detect sequences, then random stimulus against a run-length model.
module tb_otp_disp_decoder;

    localparam int STABLE = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] lfsr_out = 7'h7F;
    logic [6:0] user_out = 7'h7F;
    logic [1:0] an = 2'b11;
    logic       code_ready = 1'b0;
    logic       err_clr = 1'b0;
    logic       code_valid;
    logic [7:0] otp_code;
    logic [7:0] user_code;
    logic       match;
    logic       seg_err;
`ifdef OTP_DISP_CHANGE_DET_EN
    logic       code_changed;
`endif

    otp_disp_decoder #(.STABLE_CYCLES(STABLE)) dut (
        .clk        (clk),
        .reset      (reset),
        .lfsr_out   (lfsr_out),
        .user_out   (user_out),
        .an         (an),
        .code_ready (code_ready),
        .err_clr    (err_clr),
        .code_valid (code_valid),
        .otp_code   (otp_code),
        .user_code  (user_code),
        .match      (match),
        .seg_err    (seg_err)
`ifdef OTP_DISP_CHANGE_DET_EN
        ,
        .code_changed (code_changed)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Glyph i is the segment drive for hex value i.
    logic [6:0] glyph_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                   7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    function automatic logic [4:0] ref_decode(input logic [6:0] p);
        for (int i = 0; i < 16; i++)
            if (glyph_tbl[i] == p) return {1'b1, 4'(i)};
        return 5'h00;
    endfunction

    function automatic logic [6:0] rand_pat();
        if ($urandom_range(0, 19) == 0) return 7'($urandom);
        return glyph_tbl[$urandom_range(0, 15)];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a digit is captured when the trailing run of identical
    // (an, pattern) samples on a stream, unbroken by blank/error cycles, reaches STABLE.
    bit         m_valid, m_match, m_err, m_chg, m_seen;
    logic [7:0] m_otp, m_usr, m_last_pub;
    int         run [2];
    logic [1:0] p_an;
    logic [6:0] p_pat [2];
    logic [3:0] m_cap [2][2];
    bit         m_flag [2][2];

    task automatic model_step();
        logic [6:0] pt [2];
        logic [4:0] d [2];
        bit sel_ok, err, brk, all_f, hs;
        int dg;
        if (reset) begin
            m_valid = 0; m_match = 0; m_err = 0; m_chg = 0; m_seen = 0;
            m_otp = 0; m_usr = 0; m_last_pub = 0; p_an = 2'b11;
            for (int s = 0; s < 2; s++) begin
                run[s] = 0; p_pat[s] = 0;
                for (int k = 0; k < 2; k++) begin m_cap[s][k] = 0; m_flag[s][k] = 0; end
            end
            return;
        end
        pt[0] = lfsr_out; pt[1] = user_out;
        d[0] = ref_decode(pt[0]); d[1] = ref_decode(pt[1]);
        sel_ok = (an == 2'b10) || (an == 2'b01);
        dg     = (an == 2'b01) ? 1 : 0;
        err    = (an == 2'b00) || (sel_ok && !(d[0][4] && d[1][4]));
        brk    = err || !sel_ok;
        all_f  = m_flag[0][0] && m_flag[0][1] && m_flag[1][0] && m_flag[1][1];
        hs     = m_valid && code_ready;
        m_chg  = 0;
        if (!m_valid && all_f) begin
            m_valid = 1;
            m_otp   = {m_cap[0][1], m_cap[0][0]};
            m_usr   = {m_cap[1][1], m_cap[1][0]};
            m_match = (m_otp == m_usr);
            m_chg   = !m_seen || (m_otp != m_last_pub);
            m_seen  = 1;
            m_last_pub = m_otp;
        end else if (hs) begin
            m_valid = 0;
            m_match = 0;
        end
        if (err) m_err = 1;
        else if (err_clr) m_err = 0;
        for (int s = 0; s < 2; s++) begin
            if (brk) run[s] = 0;
            else begin
                if (run[s] > 0 && an == p_an && pt[s] == p_pat[s]) run[s]++;
                else run[s] = 1;
                if (run[s] == STABLE) begin
                    m_cap[s][dg]  = d[s][3:0];
                    m_flag[s][dg] = 1;
                end
            end
        end
        if (!brk) begin p_an = an; p_pat[0] = pt[0]; p_pat[1] = pt[1]; end
        if (hs)
            for (int s = 0; s < 2; s++)
                for (int k = 0; k < 2; k++) m_flag[s][k] = 0;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("model_out", 32'({code_valid, otp_code, user_code, match, seg_err}),
                         32'({m_valid, m_otp, m_usr, m_match, m_err}));
`ifdef OTP_DISP_CHANGE_DET_EN
        chk("model_chg", 32'(code_changed), 32'(m_chg));
`endif
    endtask

    task automatic publish(input logic [6:0] l1, input logic [6:0] l0,
                           input logic [6:0] u1, input logic [6:0] u0);
        code_ready = 0; err_clr = 0;
        an = 2'b10; lfsr_out = l0; user_out = u0;
        repeat (STABLE) tick();
        an = 2'b01; lfsr_out = l1; user_out = u1;
        repeat (STABLE) tick();
        an = 2'b11;
        tick();
    endtask

    task automatic accept();
        code_ready = 1; an = 2'b11;
        tick();
        chk("accept_valid", 32'(code_valid), 32'd0);
        code_ready = 0;
    endtask

    typedef struct {
        logic [1:0] an;
        logic [6:0] lf, us;
        logic       rdy, clr, rst;
        int         n;
        logic       e_valid;
        logic [7:0] e_otp, e_usr;
        logic       e_match, e_err;
    } vec_t;

    function automatic vec_t mk(logic [1:0] a, logic [6:0] lf, logic [6:0] us, logic rdy,
                                logic clr, logic rst, int n, logic ev, logic [7:0] eo,
                                logic [7:0] eu, logic em, logic ee);
        vec_t v;
        v.an = a; v.lf = lf; v.us = us; v.rdy = rdy; v.clr = clr; v.rst = rst; v.n = n;
        v.e_valid = ev; v.e_otp = eo; v.e_usr = eu; v.e_match = em; v.e_err = ee;
        return v;
    endfunction

    vec_t vecs [$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //                an     lf     us    rdy clr rst n  valid otp    usr    match err
        vecs.push_back(mk(2'b11, 7'h7F, 7'h7F, 0, 0, 1, 2, 0, 8'h00, 8'h00, 0, 0));
        vecs.push_back(mk(2'b10, 7'h40, 7'h40, 0, 0, 0, 4, 0, 8'h00, 8'h00, 0, 0));
        vecs.push_back(mk(2'b01, 7'h79, 7'h79, 0, 0, 0, 4, 0, 8'h00, 8'h00, 0, 0));
        vecs.push_back(mk(2'b11, 7'h79, 7'h79, 0, 0, 0, 1, 1, 8'h10, 8'h10, 1, 0));
        vecs.push_back(mk(2'b11, 7'h79, 7'h79, 1, 0, 0, 1, 0, 8'h10, 8'h10, 0, 0));
        vecs.push_back(mk(2'b10, 7'h40, 7'h40, 1, 0, 0, 4, 0, 8'h10, 8'h10, 0, 0));
        vecs.push_back(mk(2'b01, 7'h79, 7'h24, 1, 0, 0, 4, 0, 8'h10, 8'h10, 0, 0));
        vecs.push_back(mk(2'b11, 7'h79, 7'h24, 0, 0, 0, 1, 1, 8'h10, 8'h20, 0, 0));
        vecs.push_back(mk(2'b11, 7'h79, 7'h24, 1, 0, 0, 1, 0, 8'h10, 8'h20, 0, 0));
        vecs.push_back(mk(2'b10, 7'h40, 7'h40, 0, 0, 0, 3, 0, 8'h10, 8'h20, 0, 0));
        vecs.push_back(mk(2'b10, 7'h79, 7'h79, 0, 0, 0, 1, 0, 8'h10, 8'h20, 0, 0));
        vecs.push_back(mk(2'b11, 7'h79, 7'h79, 0, 0, 0, 2, 0, 8'h10, 8'h20, 0, 0));
        vecs.push_back(mk(2'b10, 7'h7F, 7'h40, 0, 0, 0, 1, 0, 8'h10, 8'h20, 0, 1));
        vecs.push_back(mk(2'b11, 7'h40, 7'h40, 0, 1, 0, 1, 0, 8'h10, 8'h20, 0, 0));
        vecs.push_back(mk(2'b10, 7'h7F, 7'h40, 0, 1, 0, 1, 0, 8'h10, 8'h20, 0, 1));
        vecs.push_back(mk(2'b11, 7'h40, 7'h40, 0, 1, 0, 1, 0, 8'h10, 8'h20, 0, 0));
        vecs.push_back(mk(2'b00, 7'h40, 7'h40, 0, 0, 0, 1, 0, 8'h10, 8'h20, 0, 1));
        vecs.push_back(mk(2'b11, 7'h40, 7'h40, 0, 1, 0, 1, 0, 8'h10, 8'h20, 0, 0));
        vecs.push_back(mk(2'b01, 7'h40, 7'h7F, 0, 0, 0, 1, 0, 8'h10, 8'h20, 0, 1));
        vecs.push_back(mk(2'b11, 7'h40, 7'h40, 0, 1, 0, 1, 0, 8'h10, 8'h20, 0, 0));

        foreach (vecs[i]) begin
            an = vecs[i].an; lfsr_out = vecs[i].lf; user_out = vecs[i].us;
            code_ready = vecs[i].rdy; err_clr = vecs[i].clr; reset = vecs[i].rst;
            repeat (vecs[i].n) tick();
            chk($sformatf("vec%0d", i),
                32'({code_valid, otp_code, user_code, match, seg_err}),
                32'({vecs[i].e_valid, vecs[i].e_otp, vecs[i].e_usr, vecs[i].e_match, vecs[i].e_err}));
        end
        reset = 0; err_clr = 0; code_ready = 0;

        // Outputs frozen in PRESENT while digits keep changing, then reset drops everything.
        publish(7'h12, 7'h08, 7'h12, 7'h08);
        chk("present_entry", 32'({code_valid, otp_code, user_code, match}), 32'({1'b1, 8'h5A, 8'h5A, 1'b1}));
        for (int i = 0; i < 10; i++) begin
            an = (i < 5) ? 2'b10 : 2'b01;
            lfsr_out = (i < 5) ? 7'h0E : 7'h06;
            user_out = (i < 5) ? 7'h21 : 7'h03;
            tick();
            chk("present_hold", 32'({code_valid, otp_code, user_code, match}), 32'({1'b1, 8'h5A, 8'h5A, 1'b1}));
        end
        reset = 1;
        tick();
        chk("reset_in_present", 32'({code_valid, otp_code, user_code, match, seg_err}), 32'd0);
        reset = 0;

        // Change detection: first publication pulses, identical repeat does not, new code does.
        publish(7'h79, 7'h24, 7'h79, 7'h24);
        chk("pub1_code", 32'(otp_code), 32'h12);
`ifdef OTP_DISP_CHANGE_DET_EN
        chk("pub1_changed", 32'(code_changed), 32'd1);
`endif
        accept();
        publish(7'h79, 7'h24, 7'h79, 7'h24);
        chk("pub2_code", 32'(otp_code), 32'h12);
`ifdef OTP_DISP_CHANGE_DET_EN
        chk("pub2_changed", 32'(code_changed), 32'd0);
`endif
        accept();
        publish(7'h30, 7'h78, 7'h30, 7'h08);
        chk("pub3_code", 32'({otp_code, user_code, match}), 32'({8'h37, 8'h3A, 1'b0}));
`ifdef OTP_DISP_CHANGE_DET_EN
        chk("pub3_changed", 32'(code_changed), 32'd1);
`endif
        accept();

        for (int b = 0; b < 160; b++) begin
            int r;
            r = $urandom_range(0, 99);
            an = (r < 45) ? 2'b10 : (r < 90) ? 2'b01 : (r < 96) ? 2'b11 : 2'b00;
            lfsr_out = rand_pat();
            user_out = ($urandom_range(0, 3) == 0) ? rand_pat() : lfsr_out;
            code_ready = ($urandom_range(0, 3) == 0);
            err_clr = ($urandom_range(0, 7) == 0);
            reset = ($urandom_range(0, 99) == 0);
            repeat ($urandom_range(1, 6)) tick();
        end
        reset = 0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/otp_disp_decoder.md
OTP_DISP_DECODER -- requirements
Module: otp_disp_decoder

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, meaning the number of consecutive identical legal samples needed to capture a digit (legal range 2..15).
REQ-002 SHALL have port clk, input, 1, the single clock; all logic is on posedge clk.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port lfsr_out, input, 7, OTP segment pattern, active-low, bit6..0 = g..a.
REQ-005 SHALL have port user_out, input, 7, user-entry segment pattern, same encoding.
REQ-006 SHALL have port an, input, 2, active-low anode select: 2'b10 = digit0, 2'b01 = digit1, 2'b11 = blank, 2'b00 = illegal.
REQ-007 SHALL have port code_ready, input, 1, consumer accepts the published codes.
REQ-008 SHALL have port err_clr, input, 1, clears seg_err.
REQ-009 SHALL have port code_valid, output, 1, published codes are valid.
REQ-010 SHALL have port otp_code, output, 8, {digit1, digit0} decoded from lfsr_out.
REQ-011 SHALL have port user_code, output, 8, {digit1, digit0} decoded from user_out.
REQ-012 SHALL have port match, output, 1, otp_code == user_code, qualified by code_valid.
REQ-013 SHALL have port seg_err, output, 1, sticky error flag.

Function
REQ-014 SHALL decode the 16 standard hex glyphs (0-9, A, b, C, d, E, F) to 4-bit values; any other pattern is illegal.
REQ-015 SHALL keep, per stream and digit, a last-sample register and a stability counter saturating at STABLE_CYCLES.
REQ-016 A sample with the same an and the same pattern as the previous cycle SHALL increment the counter; any change of an or pattern SHALL reload it to 1.
REQ-017 A digit SHALL be captured on the edge where its counter reaches STABLE_CYCLES, for lfsr_out and user_out independently, and SHALL set that digit's captured flag.
REQ-018 an = 2'b11 SHALL clear all stability counters and capture nothing.
REQ-019 an = 2'b00, or an illegal pattern on a selected digit, SHALL set seg_err and clear the counters; if set and err_clr occur together, set wins.
REQ-020 SHALL implement FSM COLLECT -> PRESENT: leave COLLECT on the edge after all four captured flags are set; in PRESENT, code_valid = 1.
REQ-021 In PRESENT, otp_code, user_code and match SHALL stay stable; sampling continues but captures SHALL NOT update the outputs.
REQ-022 On code_valid & code_ready the FSM SHALL return to COLLECT and clear all captured flags; code_valid deasserts on the next cycle.
REQ-023 Latency from the fourth flag being set to code_valid SHALL be exactly 1 cycle; code_ready while code_valid = 0 SHALL be ignored.

Reset
REQ-024 Reset SHALL force: FSM = COLLECT, code_valid = 0, otp_code = 0, user_code = 0, match = 0, seg_err = 0, all counters and flags = 0.
REQ-025 Reset during PRESENT SHALL drop code_valid on the same edge, without a handshake.

Configuration
REQ-026 With OTP_DISP_CHANGE_DET_EN defined, the module SHALL add output code_changed (1 bit): a one-cycle pulse on entry to PRESENT when otp_code differs from the previously published otp_code. The first publication after reset SHALL always pulse.
REQ-027 Without OTP_DISP_CHANGE_DET_EN, the port and the previous-code register SHALL be absent.

Structure
REQ-028 Package otp_disp_pkg SHALL hold the glyph constants, the an select constants and the FSM state enum.
REQ-029 Sub-module otp_seg7_decode SHALL be a combinational 7-bit pattern to {legal, value[3:0]} decoder, instantiated once per stream.

Verification
REQ-030 With STABLE_CYCLES = 4: an = 10, lfsr_out = user_out = 7'h40 for 4 cycles, then an = 01, both = 7'h79 for 4 cycles, then code_ready = 1 -> code_valid rises 1 cycle after the last capture; otp_code = user_code = 8'h10, match = 1.
REQ-031 As REQ-030 but user_out digit1 = 7'h24 ('2') -> user_code = 8'h20, match = 0.
REQ-032 Digit0 pattern held 3 cycles, then changed -> no capture; code_valid stays 0.
REQ-033 lfsr_out = 7'h7F (blank glyph) on a selected digit -> seg_err = 1 next edge; err_clr pulse -> seg_err = 0; err_clr together with a new illegal pattern -> seg_err stays 1.
REQ-034 In PRESENT, code_ready = 0 for 10 cycles while the digits change -> outputs unchanged; then reset -> code_valid = 0 and all outputs 0 on that edge.
REQ-035 With OTP_DISP_CHANGE_DET_EN: two identical publications -> code_changed pulses on the first only; a third with otp_code 8'h37 -> pulse.
